// File: rtl/rob_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_pkg
// Description : Shared types and constants for the reorder buffer / commit slice.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_commit_pkg;

    localparam int         c_ROBWIDTH_DEFAULT = 6;
    localparam logic [5:0] c_REG_ZERO         = 6'd0;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        reg_dest;
        logic [5:0]  write_register;
        logic        mem;
        logic        store;
        logic        mispredict;
        logic [31:0] value;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_commit_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_if
// Description : Dispatch, completion and commit-forwarding signals of the ROB.
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_commit_if #(
    parameter int ROBWIDTH = rob_commit_pkg::c_ROBWIDTH_DEFAULT
);
    logic                alloc_valid_IN;
    logic [5:0]          alloc_writeRegister_IN;
    logic                alloc_RegDest_IN;
    logic                alloc_mem_or_not_mem_IN;
    logic                alloc_MemWrite_IN;
    logic                alloc_ready_OUT;
    logic [ROBWIDTH-1:0] alloc_ROBPointer_OUT;

    logic                exe_valid_IN;
    logic [ROBWIDTH-1:0] exe_ROBPointer_IN;
    logic [31:0]         exe_Dest_Value_IN;
    logic                exe_Branch_mispredict_IN;

    logic                ls_valid_IN;
    logic [ROBWIDTH-1:0] ls_ROBPointer_IN;
    logic [31:0]         ls_Dest_Value_IN;

    logic [31:0]         fwd_data_1_COM;
    logic [5:0]          fwd_reg_1_COM;
    logic                fwd_data_1_COM_flag;
    logic [31:0]         LS_fwd_data_COM;
    logic [5:0]          LS_fwd_reg_COM;
    logic                LS_fwd_data_COM_flag;
    logic                store_commit_OUT;
    logic [ROBWIDTH-1:0] store_ROBPointer_OUT;
    logic                flush_OUT;
    logic [31:0]         redirect_PC_OUT;

    // Pipeline side: dispatch and the EXE/LS units.
    modport master (
        output alloc_valid_IN, alloc_writeRegister_IN, alloc_RegDest_IN,
               alloc_mem_or_not_mem_IN, alloc_MemWrite_IN,
               exe_valid_IN, exe_ROBPointer_IN, exe_Dest_Value_IN, exe_Branch_mispredict_IN,
               ls_valid_IN, ls_ROBPointer_IN, ls_Dest_Value_IN,
        input  alloc_ready_OUT, alloc_ROBPointer_OUT,
               fwd_data_1_COM, fwd_reg_1_COM, fwd_data_1_COM_flag,
               LS_fwd_data_COM, LS_fwd_reg_COM, LS_fwd_data_COM_flag,
               store_commit_OUT, store_ROBPointer_OUT, flush_OUT, redirect_PC_OUT
    );

    // ROB side.
    modport slave (
        input  alloc_valid_IN, alloc_writeRegister_IN, alloc_RegDest_IN,
               alloc_mem_or_not_mem_IN, alloc_MemWrite_IN,
               exe_valid_IN, exe_ROBPointer_IN, exe_Dest_Value_IN, exe_Branch_mispredict_IN,
               ls_valid_IN, ls_ROBPointer_IN, ls_Dest_Value_IN,
        output alloc_ready_OUT, alloc_ROBPointer_OUT,
               fwd_data_1_COM, fwd_reg_1_COM, fwd_data_1_COM_flag,
               LS_fwd_data_COM, LS_fwd_reg_COM, LS_fwd_data_COM_flag,
               store_commit_OUT, store_ROBPointer_OUT, flush_OUT, redirect_PC_OUT
    );
endinterface
`default_nettype wire

// File: rtl/rob_entry_array.sv
`default_nettype none
// ============================================================================
// Module      : rob_entry_array
// Description : ROB entry storage: one allocate port, two completion ports, head read.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_entry_array
    import rob_commit_pkg::*;
#(
    parameter int ROBWIDTH = c_ROBWIDTH_DEFAULT
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_clear_all,
    input  wire logic                i_alloc_en,
    input  wire logic [ROBWIDTH-1:0] i_alloc_idx,
    input  wire logic                i_alloc_reg_dest,
    input  wire logic [5:0]          i_alloc_write_register,
    input  wire logic                i_alloc_mem,
    input  wire logic                i_alloc_store,
    input  wire logic                i_exe_en,
    input  wire logic [ROBWIDTH-1:0] i_exe_idx,
    input  wire logic [31:0]         i_exe_value,
    input  wire logic                i_exe_mispredict,
    input  wire logic                i_ls_en,
    input  wire logic [ROBWIDTH-1:0] i_ls_idx,
    input  wire logic [31:0]         i_ls_value,
    input  wire logic                i_retire_en,
    input  wire logic [ROBWIDTH-1:0] i_head_idx,
    output rob_entry_t               o_head_entry
);
    localparam int c_DEPTH = 1 << ROBWIDTH;

    logic [c_DEPTH-1:0] r_valid;
    logic [c_DEPTH-1:0] r_done;
    logic [c_DEPTH-1:0] r_reg_dest;
    logic [c_DEPTH-1:0] r_mem;
    logic [c_DEPTH-1:0] r_store;
    logic [c_DEPTH-1:0] r_misp;
    logic [5:0]         r_wreg  [c_DEPTH];
    logic [31:0]        r_value [c_DEPTH];

    logic w_exe_wr;
    logic w_ls_wr;

    // Completions only land on live, not-yet-done entries; EXE wins a same-index tie.
    assign w_exe_wr = i_exe_en && r_valid[i_exe_idx] && !r_done[i_exe_idx];
    assign w_ls_wr  = i_ls_en && r_valid[i_ls_idx] && !r_done[i_ls_idx]
                   && !(i_exe_en && (i_exe_idx == i_ls_idx));

    always_ff @(posedge clk) begin
        if (rst || i_clear_all) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (i_retire_en) r_valid[i_head_idx] <= 1'b0;
            if (i_alloc_en) begin
                r_valid[i_alloc_idx] <= 1'b1;
                r_done[i_alloc_idx]  <= 1'b0;
            end
            if (w_exe_wr) r_done[i_exe_idx] <= 1'b1;
            if (w_ls_wr)  r_done[i_ls_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_alloc_en) begin
            r_reg_dest[i_alloc_idx] <= i_alloc_reg_dest;
            r_wreg[i_alloc_idx]     <= i_alloc_write_register;
            r_mem[i_alloc_idx]      <= i_alloc_mem;
            r_store[i_alloc_idx]    <= i_alloc_store;
        end
        if (w_exe_wr) begin
            r_value[i_exe_idx] <= i_exe_value;
            r_misp[i_exe_idx]  <= i_exe_mispredict;
        end
        if (w_ls_wr) begin
            r_value[i_ls_idx] <= i_ls_value;
            r_misp[i_ls_idx]  <= 1'b0;
        end
    end

    assign o_head_entry.valid          = r_valid[i_head_idx];
    assign o_head_entry.done           = r_done[i_head_idx];
    assign o_head_entry.reg_dest       = r_reg_dest[i_head_idx];
    assign o_head_entry.write_register = r_wreg[i_head_idx];
    assign o_head_entry.mem            = r_mem[i_head_idx];
    assign o_head_entry.store          = r_store[i_head_idx];
    assign o_head_entry.mispredict     = r_misp[i_head_idx];
    assign o_head_entry.value          = r_value[i_head_idx];

    a_no_dual_completion: assert property (@(posedge clk) disable iff (rst)
        !(i_exe_en && i_ls_en && (i_exe_idx == i_ls_idx)));

endmodule
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit
// Description : Reorder buffer with in-order commit, forwarding and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROBWIDTH = c_ROBWIDTH_DEFAULT
) (
    input  wire logic  CLK,
    input  wire logic  RESET,
    input  wire logic  FREEZE,
    rob_commit_if.slave bus
);
    localparam logic [ROBWIDTH:0] c_FULL = {1'b1, {ROBWIDTH{1'b0}}};

    logic [ROBWIDTH-1:0] r_head;
    logic [ROBWIDTH-1:0] r_tail;
    logic [ROBWIDTH:0]   r_count;

    logic                r_fwd_flag;
    logic [5:0]          r_fwd_reg;
    logic [31:0]         r_fwd_data;
    logic                r_ls_flag;
    logic [5:0]          r_ls_reg;
    logic [31:0]         r_ls_data;
    logic                r_store_flag;
    logic [ROBWIDTH-1:0] r_store_ptr;
    logic                r_flush;
    logic [31:0]         r_redirect;

    rob_entry_t          w_head;
    logic                w_ready;
    logic                w_alloc;
    logic                w_head_pending;
    logic                w_exe_hit;
    logic                w_ls_hit;
    logic                w_commit;
    logic                w_flush;
    logic [31:0]         w_commit_value;
    logic                w_commit_misp;
    logic [ROBWIDTH-1:0] w_head_next;

    assign w_ready = (r_count != c_FULL) && !r_flush && !FREEZE;
    assign w_alloc = bus.alloc_valid_IN && w_ready;

    // A completion aimed at a still-pending head bypasses storage and commits this edge.
    assign w_head_pending = w_head.valid && !w_head.done;
    assign w_exe_hit = bus.exe_valid_IN && (bus.exe_ROBPointer_IN == r_head) && w_head_pending;
    assign w_ls_hit  = bus.ls_valid_IN && (bus.ls_ROBPointer_IN == r_head) && w_head_pending
                    && !w_exe_hit;
    assign w_commit  = !FREEZE && w_head.valid && (w_head.done || w_exe_hit || w_ls_hit);
    assign w_flush   = w_commit && w_commit_misp;
    assign w_head_next = r_head + 1'b1;

    always_comb begin
        w_commit_value = w_head.value;
        w_commit_misp  = w_head.mispredict;
        if (!w_head.done) begin
            if (w_exe_hit) begin
                w_commit_value = bus.exe_Dest_Value_IN;
                w_commit_misp  = bus.exe_Branch_mispredict_IN;
            end else begin
                w_commit_value = bus.ls_Dest_Value_IN;
                w_commit_misp  = 1'b0;
            end
        end
    end

    rob_entry_array #(
        .ROBWIDTH (ROBWIDTH)
    ) u_entries (
        .clk                    (CLK),
        .rst                    (RESET),
        .i_clear_all            (w_flush),
        .i_alloc_en             (w_alloc && !w_flush),
        .i_alloc_idx            (r_tail),
        .i_alloc_reg_dest       (bus.alloc_RegDest_IN),
        .i_alloc_write_register (bus.alloc_writeRegister_IN),
        .i_alloc_mem            (bus.alloc_mem_or_not_mem_IN),
        .i_alloc_store          (bus.alloc_MemWrite_IN),
        .i_exe_en               (bus.exe_valid_IN && !w_flush),
        .i_exe_idx              (bus.exe_ROBPointer_IN),
        .i_exe_value            (bus.exe_Dest_Value_IN),
        .i_exe_mispredict       (bus.exe_Branch_mispredict_IN),
        .i_ls_en                (bus.ls_valid_IN && !w_flush),
        .i_ls_idx               (bus.ls_ROBPointer_IN),
        .i_ls_value             (bus.ls_Dest_Value_IN),
        .i_retire_en            (w_commit),
        .i_head_idx             (r_head),
        .o_head_entry           (w_head)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= w_head_next;
            r_tail  <= w_head_next;
            r_count <= '0;
        end else begin
            if (w_commit) r_head <= w_head_next;
            if (w_alloc)  r_tail <= r_tail + 1'b1;
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fwd_flag   <= 1'b0;
            r_fwd_reg    <= '0;
            r_fwd_data   <= '0;
            r_ls_flag    <= 1'b0;
            r_ls_reg     <= '0;
            r_ls_data    <= '0;
            r_store_flag <= 1'b0;
            r_store_ptr  <= '0;
            r_flush      <= 1'b0;
            r_redirect   <= '0;
        end else begin
            r_fwd_flag   <= 1'b0;
            r_ls_flag    <= 1'b0;
            r_store_flag <= 1'b0;
            r_flush      <= w_flush;
            if (w_flush) r_redirect <= w_commit_value;
            if (w_commit) begin
                if (w_head.reg_dest && (w_head.write_register != c_REG_ZERO) && !w_head.mem) begin
                    r_fwd_flag <= 1'b1;
                    r_fwd_reg  <= w_head.write_register;
                    r_fwd_data <= w_commit_value;
                end
                if (w_head.mem && !w_head.store && w_head.reg_dest) begin
                    r_ls_flag <= 1'b1;
                    r_ls_reg  <= w_head.write_register;
                    r_ls_data <= w_commit_value;
                end
                if (w_head.mem && w_head.store) begin
                    r_store_flag <= 1'b1;
                    r_store_ptr  <= r_head;
                end
            end
        end
    end

    assign bus.alloc_ready_OUT      = w_ready;
    assign bus.alloc_ROBPointer_OUT = r_tail;
    assign bus.fwd_data_1_COM       = r_fwd_data;
    assign bus.fwd_reg_1_COM        = r_fwd_reg;
    assign bus.fwd_data_1_COM_flag  = r_fwd_flag;
    assign bus.LS_fwd_data_COM      = r_ls_data;
    assign bus.LS_fwd_reg_COM       = r_ls_reg;
    assign bus.LS_fwd_data_COM_flag = r_ls_flag;
    assign bus.store_commit_OUT     = r_store_flag;
    assign bus.store_ROBPointer_OUT = r_store_ptr;
    assign bus.flush_OUT            = r_flush;
    assign bus.redirect_PC_OUT      = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_commit
// Description : Directed vector-table bench for rob_commit plus corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit;

    typedef struct packed {
        logic        rst;
        logic        frz;
        logic        av;
        logic [5:0]  areg;
        logic        adest;
        logic        amem;
        logic        ast;
        logic        ev;
        logic [5:0]  eptr;
        logic [31:0] eval;
        logic        emis;
        logic        lv;
        logic [5:0]  lptr;
        logic [31:0] lval;
    } in_t;

    typedef struct packed {
        logic        rdy;
        logic [5:0]  ptr;
        logic        f1;
        logic [5:0]  r1;
        logic [31:0] d1;
        logic        fl;
        logic [5:0]  rl;
        logic [31:0] dl;
        logic        st;
        logic [5:0]  sp;
        logic        fu;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk;
    logic rst;
    logic frz;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    rob_commit_if #(.ROBWIDTH(6)) bus ();

    rob_commit #(.ROBWIDTH(6)) u_dut (
        .CLK    (clk),
        .RESET  (rst),
        .FREEZE (frz),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t I_RST();
        in_t v = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic in_t I_FZ();
        in_t v = '0;
        v.frz = 1'b1;
        return v;
    endfunction

    function automatic in_t I_AL(logic [5:0] r, logic d, logic m, logic s);
        in_t v = '0;
        v.av = 1'b1; v.areg = r; v.adest = d; v.amem = m; v.ast = s;
        return v;
    endfunction

    function automatic in_t I_EX(logic [5:0] p, logic [31:0] val, logic mis);
        in_t v = '0;
        v.ev = 1'b1; v.eptr = p; v.eval = val; v.emis = mis;
        return v;
    endfunction

    function automatic in_t I_LS(logic [5:0] p, logic [31:0] val);
        in_t v = '0;
        v.lv = 1'b1; v.lptr = p; v.lval = val;
        return v;
    endfunction

    function automatic exp_t E(logic rdy, logic [5:0] ptr, logic f1, logic [5:0] r1,
                               logic [31:0] d1, logic fl, logic [5:0] rl, logic [31:0] dl,
                               logic st, logic [5:0] sp, logic fu, logic [31:0] pc);
        exp_t e;
        e.rdy = rdy; e.ptr = ptr; e.f1 = f1; e.r1 = r1; e.d1 = d1; e.fl = fl;
        e.rl = rl; e.dl = dl; e.st = st; e.sp = sp; e.fu = fu; e.pc = pc;
        return e;
    endfunction

    task automatic add(in_t i, exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, got, want);
        end
    endtask

    task automatic drive(in_t v);
        @(negedge clk);
        rst = v.rst;
        frz = v.frz;
        bus.alloc_valid_IN           = v.av;
        bus.alloc_writeRegister_IN   = v.areg;
        bus.alloc_RegDest_IN         = v.adest;
        bus.alloc_mem_or_not_mem_IN  = v.amem;
        bus.alloc_MemWrite_IN        = v.ast;
        bus.exe_valid_IN             = v.ev;
        bus.exe_ROBPointer_IN        = v.eptr;
        bus.exe_Dest_Value_IN        = v.eval;
        bus.exe_Branch_mispredict_IN = v.emis;
        bus.ls_valid_IN              = v.lv;
        bus.ls_ROBPointer_IN         = v.lptr;
        bus.ls_Dest_Value_IN         = v.lval;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_post(int idx, exp_t e);
        chk("fwd_flag",   idx, 32'(bus.fwd_data_1_COM_flag),  32'(e.f1));
        chk("fwd_reg",    idx, 32'(bus.fwd_reg_1_COM),        32'(e.r1));
        chk("fwd_data",   idx, bus.fwd_data_1_COM,            e.d1);
        chk("ls_flag",    idx, 32'(bus.LS_fwd_data_COM_flag), 32'(e.fl));
        chk("ls_reg",     idx, 32'(bus.LS_fwd_reg_COM),       32'(e.rl));
        chk("ls_data",    idx, bus.LS_fwd_data_COM,           e.dl);
        chk("store_flag", idx, 32'(bus.store_commit_OUT),     32'(e.st));
        chk("store_ptr",  idx, 32'(bus.store_ROBPointer_OUT), 32'(e.sp));
        chk("flush",      idx, 32'(bus.flush_OUT),            32'(e.fu));
        chk("redirect",   idx, bus.redirect_PC_OUT,           e.pc);
    endtask

    initial begin
        exp_t z;
        in_t  idle;
        z    = '0;
        idle = '0;
        rst  = 1'b1;
        frz  = 1'b0;

        // Out-of-order completion, in-order commit.
        add(I_RST(),                    z);
        add(I_AL(4, 1, 0, 0),           E(1, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0));
        add(I_AL(5, 1, 0, 0),           E(1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0));
        add(I_AL(6, 1, 0, 0),           E(1, 2, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0));
        add(I_EX(2, 32'h30, 0),         E(1, 3, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0));
        add(I_EX(0, 32'h10, 0),         E(1, 3, 1, 4, 32'h10,   0, 0, 0, 0, 0, 0, 0));
        add(I_EX(1, 32'h20, 0),         E(1, 3, 1, 5, 32'h20,   0, 0, 0, 0, 0, 0, 0));
        add(idle,                       E(1, 3, 1, 6, 32'h30,   0, 0, 0, 0, 0, 0, 0));
        add(idle,                       E(1, 3, 0, 6, 32'h30,   0, 0, 0, 0, 0, 0, 0));
        // Load then store.
        add(I_AL(7, 1, 1, 0),           E(1, 3, 0, 6, 32'h30,   0, 0, 0, 0, 0, 0, 0));
        add(I_AL(0, 0, 1, 1),           E(1, 4, 0, 6, 32'h30,   0, 0, 0, 0, 0, 0, 0));
        add(I_LS(4, 32'h0),             E(1, 5, 0, 6, 32'h30,   0, 0, 0, 0, 0, 0, 0));
        add(I_LS(3, 32'hDEADBEEF),      E(1, 5, 0, 6, 32'h30,   1, 7, 32'hDEADBEEF, 0, 0, 0, 0));
        add(idle,                       E(1, 5, 0, 6, 32'h30,   0, 7, 32'hDEADBEEF, 1, 4, 0, 0));
        add(idle,                       E(1, 5, 0, 6, 32'h30,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        // Register zero destination commits without a forward pulse.
        add(I_AL(0, 1, 0, 0),           E(1, 5, 0, 6, 32'h30,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        add(I_EX(5, 32'h55, 0),         E(1, 6, 0, 6, 32'h30,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        // Freeze for five cycles with a completion captured while frozen.
        add(I_AL(9, 1, 0, 0),           E(1, 6, 0, 6, 32'h30,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        add(I_EX(6, 32'h99, 0) | I_FZ(),E(0, 7, 0, 6, 32'h30,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        for (int k = 0; k < 4; k++)
            add(I_AL(10, 1, 0, 0) | I_FZ(), E(0, 7, 0, 6, 32'h30, 0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        add(idle,                       E(1, 7, 1, 9, 32'h99,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        add(idle,                       E(1, 7, 0, 9, 32'h99,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        // Reset mid-stream, with a head completion in the same cycle.
        add(I_AL(11, 1, 0, 0),          E(1, 7, 0, 9, 32'h99,   0, 7, 32'hDEADBEEF, 0, 4, 0, 0));
        add(I_AL(12, 1, 0, 0) | I_EX(7, 32'h77, 0) | I_RST(), z);
        add(I_EX(7, 32'h77, 0),         E(1, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0));
        add(I_AL(13, 1, 0, 0),          E(1, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0));
        add(I_EX(0, 32'h13, 0),         E(1, 1, 1, 13, 32'h13,  0, 0, 0, 0, 0, 0, 0));
        // Second completion to an already-done entry is ignored.
        add(I_AL(14, 1, 0, 0),          E(1, 1, 0, 13, 32'h13,  0, 0, 0, 0, 0, 0, 0));
        add(I_AL(15, 1, 0, 0),          E(1, 2, 0, 13, 32'h13,  0, 0, 0, 0, 0, 0, 0));
        add(I_EX(2, 32'hA, 0),          E(1, 3, 0, 13, 32'h13,  0, 0, 0, 0, 0, 0, 0));
        add(I_LS(2, 32'hB),             E(1, 3, 0, 13, 32'h13,  0, 0, 0, 0, 0, 0, 0));
        add(I_EX(1, 32'h1, 0),          E(1, 3, 1, 14, 32'h1,   0, 0, 0, 0, 0, 0, 0));
        add(idle,                       E(1, 3, 1, 15, 32'hA,   0, 0, 0, 0, 0, 0, 0));
        add(idle,                       E(1, 3, 0, 15, 32'hA,   0, 0, 0, 0, 0, 0, 0));
        // Both ports busy on different pointers; LS hits the head.
        add(I_AL(16, 1, 0, 0),          E(1, 3, 0, 15, 32'hA,   0, 0, 0, 0, 0, 0, 0));
        add(I_AL(17, 1, 0, 0),          E(1, 4, 0, 15, 32'hA,   0, 0, 0, 0, 0, 0, 0));
        add(I_EX(4, 32'h44, 0) | I_LS(3, 32'h33), E(1, 5, 1, 16, 32'h33, 0, 0, 0, 0, 0, 0, 0));
        add(idle,                       E(1, 5, 1, 17, 32'h44,  0, 0, 0, 0, 0, 0, 0));
        add(idle,                       E(1, 5, 0, 17, 32'h44,  0, 0, 0, 0, 0, 0, 0));

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].i);
            if (!vecs[n].i.rst) begin
                chk("alloc_ready", n, 32'(bus.alloc_ready_OUT),      32'(vecs[n].e.rdy));
                chk("alloc_ptr",   n, 32'(bus.alloc_ROBPointer_OUT), 32'(vecs[n].e.ptr));
            end
            tick();
            chk_post(n, vecs[n].e);
        end

        // Fill all 64 entries, commit while full, wrap the tail.
        drive(I_RST()); tick();
        for (int k = 0; k < 64; k++) begin
            drive(I_AL(6'(k % 62 + 1), 1, 0, 0));
            chk("fill_ready", k, 32'(bus.alloc_ready_OUT), 32'd1);
            chk("fill_ptr",   k, 32'(bus.alloc_ROBPointer_OUT), 32'(k));
            tick();
        end
        drive(I_AL(40, 1, 0, 0) | I_EX(0, 32'h100, 0));
        chk("full_ready", 0, 32'(bus.alloc_ready_OUT), 32'd0);
        chk("full_ptr",   0, 32'(bus.alloc_ROBPointer_OUT), 32'd0);
        tick();
        chk("full_commit_flag", 0, 32'(bus.fwd_data_1_COM_flag), 32'd1);
        chk("full_commit_reg",  0, 32'(bus.fwd_reg_1_COM), 32'd1);
        chk("full_commit_data", 0, bus.fwd_data_1_COM, 32'h100);
        drive(I_AL(41, 1, 0, 0));
        chk("refill_ready", 0, 32'(bus.alloc_ready_OUT), 32'd1);
        chk("refill_ptr",   0, 32'(bus.alloc_ROBPointer_OUT), 32'd0);
        tick();
        drive(idle);
        chk("wrap_ready", 0, 32'(bus.alloc_ready_OUT), 32'd0);
        chk("wrap_ptr",   0, 32'(bus.alloc_ROBPointer_OUT), 32'd1);
        tick();

        // Mispredicted branch at pointer 3 with younger completed entries.
        drive(I_RST()); tick();
        drive(I_AL(1, 1, 0, 0));  tick();
        drive(I_AL(2, 1, 0, 0));  tick();
        drive(I_AL(3, 1, 0, 0));  tick();
        drive(I_AL(31, 1, 0, 0)); tick();
        drive(I_AL(20, 1, 0, 0)); tick();
        drive(I_AL(21, 1, 0, 0)); tick();
        drive(I_AL(22, 1, 0, 0)); tick();
        for (int k = 4; k < 7; k++) begin
            drive(I_EX(6'(k), 32'(k) * 32'h11, 0)); tick();
            chk("young_no_commit", k, 32'(bus.fwd_data_1_COM_flag), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(I_EX(6'(k), 32'h1000 + 32'(k), 0)); tick();
            chk("old_commit_reg",  k, 32'(bus.fwd_reg_1_COM), 32'(k + 1));
            chk("old_commit_data", k, bus.fwd_data_1_COM, 32'h1000 + 32'(k));
        end
        drive(I_EX(3, 32'h400, 1) | I_AL(9, 1, 0, 0));
        chk("br_ready", 0, 32'(bus.alloc_ready_OUT), 32'd1);
        chk("br_ptr",   0, 32'(bus.alloc_ROBPointer_OUT), 32'd7);
        tick();
        chk("flush_pulse", 0, 32'(bus.flush_OUT), 32'd1);
        chk("flush_pc",    0, bus.redirect_PC_OUT, 32'h400);
        chk("br_fwd_flag", 0, 32'(bus.fwd_data_1_COM_flag), 32'd1);
        chk("br_fwd_reg",  0, 32'(bus.fwd_reg_1_COM), 32'd31);
        drive(idle);
        chk("flush_ready", 0, 32'(bus.alloc_ready_OUT), 32'd0);
        chk("flush_tail",  0, 32'(bus.alloc_ROBPointer_OUT), 32'd4);
        tick();
        chk("flush_clear", 0, 32'(bus.flush_OUT), 32'd0);
        chk("flush_pc_hold", 0, bus.redirect_PC_OUT, 32'h400);
        for (int k = 0; k < 3; k++) begin
            drive(idle);
            chk("post_flush_ready", k, 32'(bus.alloc_ready_OUT), 32'd1);
            chk("post_flush_ptr",   k, 32'(bus.alloc_ROBPointer_OUT), 32'd4);
            tick();
            chk("squashed_no_commit", k, 32'(bus.fwd_data_1_COM_flag), 32'd0);
        end
        for (int k = 0; k < 64; k++) begin
            drive(I_AL(6'd5, 1, 0, 0));
            chk("empty_ready", k, 32'(bus.alloc_ready_OUT), 32'd1);
            chk("empty_ptr",   k, 32'(bus.alloc_ROBPointer_OUT), 32'((k + 4) % 64));
            tick();
        end
        drive(idle);
        chk("empty_full", 0, 32'(bus.alloc_ready_OUT), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer and in-order commit stage at the far end of the EXE/LS result path.
- Allocates one ROB entry per dispatched instruction and hands its pointer downstream.
- Captures out-of-order completions from the EXE (ALU) port and the LS port, then retires one entry per cycle in program order.
- At retirement it drives the commit-forwarding buses that EXE consumes (fwd_*_COM, LS_fwd_*_COM), and it raises a flush/redirect when a mispredicted branch retires.

Parameters:
- ROBWIDTH, 6, log2 of entry count (64 entries at the default).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- FREEZE  in  1  blocks allocation and commit; completions are still captured.
- alloc_valid_IN  in  1  dispatch requests an entry.
- alloc_writeRegister_IN  in  6  destination register.
- alloc_RegDest_IN  in  1  instruction writes a register.
- alloc_mem_or_not_mem_IN  in  1  instruction is a load/store.
- alloc_MemWrite_IN  in  1  instruction is a store.
- alloc_ready_OUT  out  1  an entry is available this cycle.
- alloc_ROBPointer_OUT  out  ROBWIDTH  pointer granted (the current tail).
- exe_valid_IN  in  1  ALU completion.
- exe_ROBPointer_IN  in  ROBWIDTH  ALU completion pointer.
- exe_Dest_Value_IN  in  32  ALU result, or branch target.
- exe_Branch_mispredict_IN  in  1  resolved branch was mispredicted.
- ls_valid_IN  in  1  LS completion.
- ls_ROBPointer_IN  in  ROBWIDTH  LS completion pointer.
- ls_Dest_Value_IN  in  32  load data (don't-care for stores).
- fwd_data_1_COM  out  32  committed ALU value.
- fwd_reg_1_COM  out  6  committed ALU destination.
- fwd_data_1_COM_flag  out  1  pulse: ALU register commit.
- LS_fwd_data_COM  out  32  committed load value.
- LS_fwd_reg_COM  out  6  committed load destination.
- LS_fwd_data_COM_flag  out  1  pulse: load register commit.
- store_commit_OUT  out  1  pulse: store retired; LS may write memory.
- store_ROBPointer_OUT  out  ROBWIDTH  pointer of the retired store.
- flush_OUT  out  1  pulse: mispredict retired.
- redirect_PC_OUT  out  32  fetch target that accompanies flush_OUT.

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - head, tail and count go to 0.
  - All entry valid/done bits clear.
  - All outputs go to 0.
- Entry fields: valid, done, RegDest, writeRegister[5:0], mem, store, mispredict, value[31:0].
- Pointers are ROBWIDTH bits and wrap naturally modulo 2^ROBWIDTH. count is ROBWIDTH+1 bits.
- alloc_ready_OUT is combinational from registered state: count != 2^ROBWIDTH && !flush_OUT && !FREEZE.
  - When the ROB is full, allocation is refused even if a commit happens in the same cycle.
- alloc_ROBPointer_OUT always equals tail.
- Allocation: on an edge with alloc_valid_IN && alloc_ready_OUT, the entry at tail gets valid=1, done=0 and the stored fields; tail increments.
- Completion: on an edge with exe_valid_IN, the entry at exe_ROBPointer_IN gets done=1 and value captured.
  - mispredict is captured from exe_Branch_mispredict_IN.
  - LS completion is identical, with mispredict forced to 0.
  - A completion to an invalid or already-done entry is ignored.
  - If both ports target the same pointer in one cycle, the EXE port wins; this is a protocol violation and an assertion fires.
  - A completion is captured even while FREEZE is high.
- Commit occurs at an edge when !FREEZE and head.valid && head.done, or head.valid and a completion to head arrives that cycle. The second case is a bypass: the completion value is used directly.
- On commit:
  - head increments and entry valid clears.
  - If RegDest=1, writeRegister!=0 and !mem: fwd_data_1_COM, fwd_reg_1_COM and fwd_data_1_COM_flag=1 are registered.
  - If a load with RegDest: the LS_fwd_* outputs are registered likewise.
  - If a store: store_commit_OUT=1 and store_ROBPointer_OUT are registered.
  - All flags are 1-cycle pulses, cleared on the next edge unless another commit occurs. Data/reg outputs hold their last value.
- Mispredict commit: the entry's normal register forward still occurs. In addition, flush_OUT=1 and redirect_PC_OUT=value are set, every valid bit clears, tail<=head+1 (the new head), count<=0, and any same-cycle allocation or completion is discarded.
- count update: +1 on allocate, -1 on commit, unchanged when both or neither occur, and 0 on flush.
- Latency: a completion to the head is visible on the forward outputs one edge later (minimum commit latency 1 cycle).
- RESET asserted mid-operation discards all entries with no commit pulses.

Decomposition:
- Shared package:
  - ROB entry struct.
  - ROBWIDTH default.
  - Register-zero constant.
- Sub-module rob_entry_array: the entry storage.
  - One allocate write port, two completion write ports, one head read port.
  - Priority is allocate > exe > ls on the same index. Exe-over-ls is the protocol-violation rule above. Allocate can only target the tail, which holds no valid entry, so completions there are ignored.
- Top-level rob_commit holds the pointers, count, commit/flush logic and output registers.

Test Plan:
- Reset, allocate 3 ALU ops (regs 4, 5, 6), complete them out of order (ptr2=0x30, ptr0=0x10, ptr1=0x20) -> fwd_reg_1_COM sequence 4, 5, 6 with data 0x10, 0x20, 0x30 on consecutive cycles; no commit before ptr0 completes.
- Allocate 64 entries with none complete -> alloc_ready_OUT=0 after the 64th. Complete ptr0 -> ready returns the cycle after the commit. Tail wraps to 0 on the next allocation.
- Load to reg 7 completes via the LS port with 0xDEADBEEF; store at ptr+1 -> LS_fwd_reg_COM=7 with data 0xDEADBEEF, next cycle store_commit_OUT=1 with the store's pointer.
- Branch at ptr 3 with mispredict and target 0x400, younger entries 4–6 completed -> flush_OUT=1, redirect_PC_OUT=0x400; entries 4–6 never commit; head=tail=4, count=0.
- FREEZE high for 5 cycles while the head is done -> no commit or allocation; completions still captured; commits resume on the first unfrozen edge.
- Writes to reg 0 commit with no fwd flag. RESET held for 1 cycle mid-stream -> all outputs 0, count 0.
